// File: rtl/exe_task_dispatcher_pkg.sv
// exe_task_dispatcher_pkg
//   Shared types and constants for the execution-unit task dispatcher:
//   FSM state encoding, result-code bit positions and a result packer.
package exe_task_dispatcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_REPORT = 3'd3,
        ST_HALT   = 3'd4
    } dispState_t;

    localparam int RESULT_RC_BIT      = 0;
    localparam int RESULT_TIMEOUT_BIT = 1;

    function automatic logic [1:0] packResult(input logic rc, input logic timedOut);
        logic [1:0] r;
        r                     = '0;
        r[RESULT_RC_BIT]      = rc;
        r[RESULT_TIMEOUT_BIT] = timedOut;
        return r;
    endfunction

endpackage

// File: rtl/exe_task_dispatcher_if.sv
// exe_task_dispatcher_if
//   Bundles the dispatcher's host task channel, execution-unit trigger/done
//   channel, result channel and status flags.
//   slave  : the dispatcher side (drives oTaskReady, oTrigger, results, status)
//   master : the host / execution-unit side (drives iTask*, iFlush, iExe*, iResultReady)
interface exe_task_dispatcher_if #(
    parameter int ADDR_W = 16
);
    logic              iTaskValid;
    logic [ADDR_W-1:0] iTaskAddress;
    logic              oTaskReady;
    logic              iFlush;
    logic              oTrigger;
    logic [ADDR_W-1:0] oInitialCodeAddress;
    logic              iExeDone;
    logic              iExeReturnCode;
    logic              oResultValid;
    logic [ADDR_W-1:0] oResultAddress;
    logic [1:0]        oResultCode;
    logic              iResultReady;
    logic              oBusy;
    logic              oFault;

    modport slave (
        input  iTaskValid, iTaskAddress, iFlush, iExeDone, iExeReturnCode, iResultReady,
        output oTaskReady, oTrigger, oInitialCodeAddress, oResultValid, oResultAddress,
               oResultCode, oBusy, oFault
    );

    modport master (
        output iTaskValid, iTaskAddress, iFlush, iExeDone, iExeReturnCode, iResultReady,
        input  oTaskReady, oTrigger, oInitialCodeAddress, oResultValid, oResultAddress,
               oResultCode, oBusy, oFault
    );

endinterface

// File: rtl/exe_task_dispatcher_task_fifo.sv
// task_fifo
//   Synchronous FIFO holding queued task entry addresses.
//   Ports: Clock, Reset (async active-low), push/pushData, pop, flush,
//          full, empty, headData (entry at the read pointer).
//   Flush dominates push and pop in the same cycle; a push while full is
//   dropped even if a pop happens in that cycle.
module task_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] headData
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr, rdPtr;
    logic [PW:0]      count;
    logic             doPush, doPop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign headData = mem[rdPtr];
    assign doPush   = push && !full && !flush;
    assign doPop    = pop && !empty && !flush;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge Clock) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/exe_task_dispatcher.sv
// exe_task_dispatcher
//   Queues host tasks (entry code addresses), launches each on the execution
//   unit with a one-cycle trigger, waits for a rising edge of done (or a
//   timeout) and presents the result to the host.
//   Ports: Clock, Reset (async active-low), bus (exe_task_dispatcher_if.slave).
//   A timeout sets a sticky fault; after its result is taken the block parks
//   in HALT until iFlush.
module exe_task_dispatcher
    import exe_task_dispatcher_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic Clock,
    input  logic Reset,
    exe_task_dispatcher_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dispState_t        state;
    logic [ADDR_W-1:0] addrReg;
    logic [CNT_W-1:0]  waitCnt;
    logic              doneQ;
    logic [1:0]        resultCode;
    logic              resultValid;
    logic              fault;
    logic              trigger;

    logic              qFull, qEmpty;
    logic [ADDR_W-1:0] qHead;
    logic              launch;
    logic              doneEdge;

    // Flush in IDLE suppresses the pop, so nothing launches that cycle.
    assign launch   = (state == ST_IDLE) && !qEmpty && !bus.iFlush;
    assign doneEdge = bus.iExeDone && !doneQ;

    task_fifo #(.WIDTH(ADDR_W), .DEPTH(QUEUE_DEPTH)) uFifo (
        .Clock    (Clock),
        .Reset    (Reset),
        .push     (bus.iTaskValid),
        .pushData (bus.iTaskAddress),
        .pop      (launch),
        .flush    (bus.iFlush),
        .full     (qFull),
        .empty    (qEmpty),
        .headData (qHead)
    );

    assign bus.oTaskReady          = !qFull;
    assign bus.oTrigger            = trigger;
    assign bus.oInitialCodeAddress = addrReg;
    // addrReg only changes on a pop in IDLE, so it is stable through REPORT.
    assign bus.oResultAddress      = addrReg;
    assign bus.oResultValid        = resultValid;
    assign bus.oResultCode         = resultCode;
    assign bus.oFault              = fault;
    assign bus.oBusy               = !((state == ST_IDLE) && qEmpty);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            addrReg     <= '0;
            waitCnt     <= '0;
            doneQ       <= 1'b0;
            resultCode  <= '0;
            resultValid <= 1'b0;
            fault       <= 1'b0;
            trigger     <= 1'b0;
        end else begin
            doneQ <= bus.iExeDone;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        addrReg <= qHead;
                        trigger <= 1'b1;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    trigger <= 1'b0;
                    waitCnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done edge is checked first so it wins a tie with timeout.
                    if (doneEdge) begin
                        resultCode  <= packResult(bus.iExeReturnCode, 1'b0);
                        resultValid <= 1'b1;
                        state       <= ST_REPORT;
                    end else if (waitCnt == CNT_LAST) begin
                        resultCode  <= packResult(1'b0, 1'b1);
                        resultValid <= 1'b1;
                        fault       <= 1'b1;
                        state       <= ST_REPORT;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (bus.iResultReady) begin
                        resultValid <= 1'b0;
                        state       <= fault ? ST_HALT : ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (bus.iFlush) begin
                        fault <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
